ioctl_mem_writer: RTL and testbench

IOCTL_MEM_WRITER -- requirements
Module: ioctl_mem_writer

---
 rtl/ioctl_mem_writer_pkg.sv | 23 ++
 rtl/ioctl_mem_writer_fifo.sv | 64 ++++++
 rtl/ioctl_mem_writer.sv | 142 ++++++++++++++
 tb/tb_ioctl_mem_writer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_mem_writer_pkg.sv
// Shared types and widths for the ioctl download-to-memory writer.
// Holds the FSM state encoding, bus widths and the buffered entry layout.
// No logic; imported by the writer and its FIFO instance.
package ioctl_mem_writer_pkg;

   localparam int IOCTL_AW = 25;
   localparam int IOCTL_DW = 16;
   localparam int ENTRY_W  = IOCTL_AW + IOCTL_DW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // One buffered write: memory byte address (base already added) and data.
   typedef struct packed {
      logic [IOCTL_AW-1:0] addr;
      logic [IOCTL_DW-1:0] data;
   } entry_t;

endpackage

// File: rtl/ioctl_mem_writer_fifo.sv
// Synchronous FIFO, registered count; push ignored when full, pop ignored when empty.
// Latency: a pushed word is visible at the head one cycle after the push.
// No bypass: the head is always read from storage, never from the push port.
module sync_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_MAX);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; only slots below the count are ever read out.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ioctl_mem_writer.sv
// Buffers ioctl download words and writes them to memory via a req/ack handshake.
// Latency: word pushed in cycle N reaches mem_req at N+2; back-to-back requests every 2 cycles.
// Backpressure: ioctl_wait at count >= FIFO_DEPTH-2; writes arriving while full are dropped and flagged.
module ioctl_mem_writer
   import ioctl_mem_writer_pkg::*;
#(
   parameter int                  FIFO_DEPTH = 4,
   parameter logic [IOCTL_AW-1:0] BASE_ADDR  = 25'h0
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ioctl_download,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_wr,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   input  logic [IOCTL_DW-1:0] ioctl_dout,
   output logic                ioctl_wait,
   output logic                mem_req,
   output logic [IOCTL_AW-1:0] mem_addr,
   output logic [IOCTL_DW-1:0] mem_din,
   input  logic                mem_ack,
   output logic                load_done,
   output logic [7:0]          load_index,
   output logic [IOCTL_AW-1:0] load_size,
   output logic                overflow
);

   localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]  WAIT_LVL = CW'(FIFO_DEPTH - 2);
   localparam logic [IOCTL_AW-1:0] TWO = 25'd2;

   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic [IOCTL_AW-1:0] mem_addr_q, mem_addr_d;
   logic [IOCTL_DW-1:0] mem_din_q, mem_din_d;
   logic [7:0]          load_index_q, load_index_d;
   logic [IOCTL_AW-1:0] load_size_q, load_size_d;
   logic                overflow_q, overflow_d;

   logic                start, wr_window, wr_take, fifo_push, fifo_pop;
   logic                fifo_full, fifo_empty;
   logic [CW-1:0]       fifo_count;
   logic [IOCTL_AW-1:0] wr_end;
   entry_t              push_ent, head_ent;
   logic [ENTRY_W-1:0]  head_raw;

   // Writes are taken in LOAD and in the very cycle a download starts.
   assign start     = (state_q == IDLE) && ioctl_download;
   assign wr_window = (state_q == LOAD) || start;
   assign wr_take   = ioctl_wr && wr_window;
   assign fifo_push = wr_take && !fifo_full;
   assign fifo_pop  = mem_req_q && mem_ack;
   assign wr_end    = ioctl_addr + TWO;

   assign push_ent.addr = ioctl_addr + BASE_ADDR;
   assign push_ent.data = ioctl_dout;
   assign head_ent      = entry_t'(head_raw);

   assign ioctl_wait = (fifo_count >= WAIT_LVL);
   assign load_done  = (state_q == DONE);
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign load_index = load_index_q;
   assign load_size  = load_size_q;
   assign overflow   = overflow_q;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_sys),
      .rst_ni  (reset_n),
      .push_i  (fifo_push),
      .din_i   (push_ent),
      .pop_i   (fifo_pop),
      .dout_o  (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Session sequencing: LOAD until download drops, drain the buffer, pulse done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ioctl_download) state_d = LOAD;
         LOAD:    if (!ioctl_download) state_d = DRAIN;
         DRAIN:   if (fifo_empty && !mem_req_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Session status and the memory request; the request captures the head once and holds it.
   always_comb begin
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      load_index_d = load_index_q;
      load_size_d  = load_size_q;
      overflow_d   = overflow_q;

      if (start) begin
         load_index_d = ioctl_index;
         load_size_d  = '0;
         overflow_d   = 1'b0;
      end
      if (fifo_push && (wr_end > load_size_d)) load_size_d = wr_end;
      if (wr_take && fifo_full) overflow_d = 1'b1;

      if (mem_req_q) begin
         if (mem_ack) mem_req_d = 1'b0;
      end else if (!fifo_empty) begin
         mem_req_d  = 1'b1;
         mem_addr_d = head_ent.addr;
         mem_din_d  = head_ent.data;
      end
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         load_index_q <= '0;
         load_size_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         load_index_q <= load_index_d;
         load_size_q  <= load_size_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_ioctl_mem_writer.sv
// Self-checking bench for ioctl_mem_writer with a queue-based reference model.
// One cycle per tick(): model update at the falling edge, stimulus 1 time unit after the rising edge.
// Memory acknowledge is produced by a mode-selectable responder inside tick().
module tb_ioctl_mem_writer;

   localparam int          DEPTH = 4;
   localparam logic [24:0] BASE  = 25'h100000;

   typedef struct {
      logic [24:0] a;
      logic [15:0] d;
   } word_t;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = '0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [15:0] ioctl_dout = '0;
   logic        ioctl_wait;
   logic        mem_req;
   logic [24:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_ack = 1'b0;
   logic        load_done;
   logic [7:0]  load_index;
   logic [24:0] load_size;
   logic        overflow;

   word_t       exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          wr_cnt = 0;
   int          max_pend = 0;
   bit          exp_ovf = 0;
   logic [24:0] exp_size = '0;
   bit          wr_ok = 1;
   int          ack_mode = 0;
   int          ack_dly = 0;

   ioctl_mem_writer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_ack        (mem_ack),
      .load_done      (load_done),
      .load_index     (load_index),
      .load_size      (load_size),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // One clock cycle: predict what the coming edge does, then respond to memory.
   task automatic tick();
      word_t w;
      bit    full;
      logic  exp_wait;
      @(negedge clk_sys);
      if (!reset_n) begin
         exp_q.delete();
         exp_ovf  = 0;
         exp_size = '0;
      end else begin
         exp_wait = (exp_q.size() >= DEPTH - 2);
         checks++;
         if (ioctl_wait !== exp_wait) begin
            errors++;
            $display("FAIL ioctl_wait t=%0t got %b want %b", $time, ioctl_wait, exp_wait);
         end
         full = (exp_q.size() == DEPTH);
         if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            checks++;
            wr_cnt++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL mem_write unexpected got (%h,%h) want none", mem_addr, mem_din);
            end else begin
               w = exp_q.pop_front();
               if (mem_addr !== w.a || mem_din !== w.d) begin
                  errors++;
                  $display("FAIL mem_write got (%h,%h) want (%h,%h)", mem_addr, mem_din, w.a, w.d);
               end
            end
         end
         if (ioctl_wr && wr_ok) begin
            if (full) exp_ovf = 1;
            else begin
               w.a = ioctl_addr + BASE;
               w.d = ioctl_dout;
               exp_q.push_back(w);
               if (ioctl_addr + 25'd2 > exp_size) exp_size = ioctl_addr + 25'd2;
            end
         end
         if (exp_q.size() > max_pend) max_pend = exp_q.size();
         if (load_done === 1'b1) done_cnt++;
      end
      @(posedge clk_sys);
      #1;
      case (ack_mode)
         1: mem_ack = mem_req && !mem_ack;
         2: begin
            if (mem_ack) begin
               mem_ack = 1'b0;
               ack_dly = $urandom_range(0, 3);
            end else if (mem_req) begin
               if (ack_dly == 0) mem_ack = 1'b1;
               else ack_dly--;
            end
         end
         default: mem_ack = 1'b0;
      endcase
   endtask

   task automatic wr(input logic [24:0] a, input logic [15:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start = done_cnt;
      for (int i = 0; i < 200 && done_cnt == start; i++) tick();
      checks++;
      if (done_cnt == start) begin
         errors++;
         $display("FAIL %s_timeout got no load_done want one", name);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({mem_req, load_done, overflow, ioctl_wait} !== 4'b0 ||
          load_size !== '0 || load_index !== '0 || mem_addr !== '0 || mem_din !== '0) begin
         errors++;
         $display("FAIL reset_state got req=%b done=%b ovf=%b wait=%b size=%h idx=%h addr=%h din=%h want all 0",
                  mem_req, load_done, overflow, ioctl_wait, load_size, load_index, mem_addr, mem_din);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int d0 = done_cnt, w0 = wr_cnt;
      ack_mode = 1;
      ioctl_download = 1'b1;
      ioctl_index    = 8'h03;
      wr(25'h0, 16'h1234);
      wr(25'h2, 16'h5678);
      ioctl_download = 1'b0;
      wait_done("basic");
      repeat (3) tick();
      checks++;
      if (done_cnt - d0 != 1 || wr_cnt - w0 != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_counts got done=%0d writes=%0d left=%0d want 1 2 0",
                  done_cnt - d0, wr_cnt - w0, exp_q.size());
      end
      checks++;
      if (load_size !== 25'd4 || load_index !== 8'h03 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_status got size=%h idx=%h ovf=%b want 4 03 0", load_size, load_index, overflow);
      end
   endtask

   task automatic test_backpressure();
      int sent = 0, w0 = wr_cnt;
      bit saw_wait = 0;
      ack_mode = 0;
      exp_size = '0;
      ioctl_download = 1'b1;
      ioctl_index = 8'($urandom);
      for (int c = 0; c < 10; c++) begin
         if (ioctl_wait) saw_wait = 1;
         else if (sent < 6) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(sent * 2);
            ioctl_dout = 16'($urandom);
            sent++;
         end
         tick();
         ioctl_wr = 1'b0;
      end
      checks++;
      if (!saw_wait || ioctl_wait !== 1'b1 || exp_q.size() != 2 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold got saw=%0d wait=%b pend=%0d ovf=%b want 1 1 2 0",
                  saw_wait, ioctl_wait, exp_q.size(), overflow);
      end
      ack_mode = 1;
      for (int c = 0; c < 60 && sent < 6; c++) begin
         if (!ioctl_wait) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(sent * 2);
            ioctl_dout = 16'($urandom);
            sent++;
         end
         tick();
         ioctl_wr = 1'b0;
      end
      ioctl_download = 1'b0;
      wait_done("bp");
      tick();
      checks++;
      if (ioctl_wait !== 1'b0 || overflow !== 1'b0 || wr_cnt - w0 != 6 || load_size !== exp_size) begin
         errors++;
         $display("FAIL bp_drain got wait=%b ovf=%b writes=%0d size=%h want 0 0 6 %h",
                  ioctl_wait, overflow, wr_cnt - w0, load_size, exp_size);
      end
   endtask

   task automatic test_overflow();
      int w0 = wr_cnt;
      ack_mode = 0;
      exp_size = '0;
      exp_ovf  = 0;
      ioctl_download = 1'b1;
      ioctl_index = 8'h5a;
      for (int i = 0; i < 5; i++) wr(25'(i * 2), 16'($urandom));
      checks++;
      if (overflow !== 1'b1 || !exp_ovf || exp_q.size() != DEPTH) begin
         errors++;
         $display("FAIL ovf_flag got ovf=%b model=%0d pend=%0d want 1 1 %0d", overflow, exp_ovf, exp_q.size(), DEPTH);
      end
      ioctl_download = 1'b0;
      tick();
      wr_ok = 0;
      wr(25'h40, 16'hdead);
      wr_ok = 1;
      ack_mode = 2;
      wait_done("ovf");
      checks++;
      if (wr_cnt - w0 != 4 || overflow !== 1'b1 || load_size !== 25'd8) begin
         errors++;
         $display("FAIL ovf_drain got writes=%0d ovf=%b size=%h want 4 1 8", wr_cnt - w0, overflow, load_size);
      end
   endtask

   task automatic test_simultaneous();
      int w0 = wr_cnt;
      ack_mode = 1;
      exp_size = '0;
      max_pend = 0;
      ioctl_download = 1'b1;
      ioctl_index = 8'h07;
      for (int i = 0; i < 16; i++) begin
         wr(25'(i * 2), 16'($urandom));
         tick();
      end
      ioctl_download = 1'b0;
      wait_done("simul");
      checks++;
      if (max_pend > 1 || wr_cnt - w0 != 16 || exp_q.size() != 0 || load_size !== 25'd32) begin
         errors++;
         $display("FAIL simul got maxpend=%0d writes=%0d left=%0d size=%h want <=1 16 0 20",
                  max_pend, wr_cnt - w0, exp_q.size(), load_size);
      end
   endtask

   task automatic test_reset_mid();
      int d0, w0;
      ack_mode = 0;
      ioctl_download = 1'b1;
      ioctl_index = 8'h44;
      for (int i = 0; i < 3; i++) wr(25'(i * 2), 16'($urandom));
      tick();
      checks++;
      if (mem_req !== 1'b1 || exp_q.size() != 3) begin
         errors++;
         $display("FAIL rst_pre got req=%b pend=%0d want 1 3", mem_req, exp_q.size());
      end
      d0 = done_cnt;
      w0 = wr_cnt;
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      checks++;
      if (mem_req !== 1'b0 || load_done !== 1'b0 || ioctl_wait !== 1'b0 ||
          load_index !== 8'h00 || load_size !== '0) begin
         errors++;
         $display("FAIL rst_post got req=%b done=%b wait=%b idx=%h size=%h want 0 0 0 00 0",
                  mem_req, load_done, ioctl_wait, load_index, load_size);
      end
      ack_mode = 1;
      repeat (6) tick();
      checks++;
      if (done_cnt != d0 || wr_cnt != w0 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_quiet got done=%0d writes=%0d req=%b want 0 0 0", done_cnt - d0, wr_cnt - w0, mem_req);
      end
      test_basic();
   endtask

   task automatic test_back_to_back();
      logic [24:0] s1;
      ack_mode = 2;
      exp_size = '0;
      ioctl_download = 1'b1;
      ioctl_index = 8'h11;
      for (int i = 0; i < 4; i++) wr(25'($urandom) & 25'h0fffffe, 16'($urandom));
      s1 = exp_size;
      ioctl_download = 1'b0;
      tick();
      tick();
      ioctl_download = 1'b1;
      ioctl_index = 8'h22;
      wait_done("b2b_first");
      checks++;
      if (load_index !== 8'h11 || load_size !== s1) begin
         errors++;
         $display("FAIL b2b_first got idx=%h size=%h want 11 %h", load_index, load_size, s1);
      end
      exp_size = '0;
      tick();
      tick();
      checks++;
      if (load_index !== 8'h22 || load_size !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_start got idx=%h size=%h ovf=%b want 22 0 0", load_index, load_size, overflow);
      end
      for (int i = 0; i < 3; i++) wr(25'($urandom) & 25'h0fffffe, 16'($urandom));
      ioctl_download = 1'b0;
      wait_done("b2b_second");
      checks++;
      if (load_index !== 8'h22 || load_size !== exp_size || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_second got idx=%h size=%h left=%0d want 22 %h 0", load_index, load_size, exp_q.size(), exp_size);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
